// File: rtl/bid_requester_if.sv
// Request/arbiter bundle for bid_requester: client request handshake, arbiter bid/grant,
// and the transfer/status outputs. master = requester side, slave = client/arbiter side.
interface bid_requester_if;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_len;
    logic [3:0] req_prio;
    logic       grant;
    logic [3:0] bid;
    logic [9:0] balance;
    logic       xfer_beat;
    logic       xfer_last;
    logic       starve;

    modport master (
        input  req_valid, req_len, req_prio, grant,
        output req_ready, bid, balance, xfer_beat, xfer_last, starve
    );

    modport slave (
        output req_valid, req_len, req_prio, grant,
        input  req_ready, bid, balance, xfer_beat, xfer_last, starve
    );
endinterface

// File: rtl/bid_requester.sv
// Credit-based bidding bus master: bids latched priority against a refilled balance.
// Optional macro BID_AGING_EN raises the effective priority during long bid waits.
module bid_requester #(
    parameter int BAL_INIT      = 750,
    parameter int BAL_MAX       = 900,
    parameter int REFILL_AMT    = 750,
    parameter int REFILL_PERIOD = 400,
    parameter int STARVE_LIM    = 60
) (
    input  logic            clk,
    input  logic            rst,
    bid_requester_if.master bus
);
    // state | meaning
    // IDLE  | ready for a request, counters cleared
    // BID   | presenting bid, waiting for a winning grant
    // XFER  | moving beats while grant is held
    // DONE  | one-cycle completion gap, bid forced to 0
    typedef enum logic [1:0] {IDLE, BID, XFER, DONE} state_t;

    localparam int              RC_W       = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;
    localparam logic [RC_W-1:0] RC_LAST    = RC_W'(REFILL_PERIOD - 1);
    localparam logic [10:0]     BAL_INIT_W = 11'(BAL_INIT);
    localparam logic [11:0]     BAL_MAX_W  = 12'(BAL_MAX);
    localparam logic [11:0]     REFILL_W   = 12'(REFILL_AMT);
    localparam logic [6:0]      STARVE_V   = (STARVE_LIM > 64) ? 7'd64 : 7'(STARVE_LIM);

    state_t          state_q, state_d;
    logic [3:0]      len_q, prio_q, beat_q, win_q;
    logic [5:0]      wait_q;
    logic [RC_W-1:0] rc_q;
    logic [10:0]     bal_q, bal_m1, bal_ref, bal_d;
    logic [11:0]     bal_sum;
    logic [3:0]      prio_in, prio_eff, bid_calc;
    logic            refill_wrap, deduct;
    logic            ready_c, beat_c, last_c;
    logic [3:0]      bid_c;

    assign prio_in     = (bus.req_prio == 4'd0) ? 4'd1 : bus.req_prio;
    assign refill_wrap = (rc_q == RC_LAST);
    assign bal_m1      = bal_q - 11'd1;

    always_comb begin
        bid_calc = 4'd0;
        if (bal_q <= 11'd1)
            bid_calc = 4'd0;
        else if ({7'd0, prio_eff} <= bal_m1)
            bid_calc = prio_eff;
        else
            bid_calc = bal_m1[3:0];
    end

    assign deduct = (state_q == BID) && bus.grant && (bid_calc != 4'd0);

    // Refill lands before the deduction on a shared edge; both clamp instead of wrapping.
    always_comb begin
        bal_sum = {1'b0, bal_q} + REFILL_W;
        bal_ref = bal_q;
        if (refill_wrap)
            bal_ref = (bal_sum > BAL_MAX_W) ? BAL_MAX_W[10:0] : bal_sum[10:0];
        bal_d = bal_ref;
        if (deduct)
            bal_d = (bal_ref >= {7'd0, bid_calc}) ? (bal_ref - {7'd0, bid_calc}) : 11'd0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready_c = 1'b0;
        bid_c   = 4'd0;
        beat_c  = 1'b0;
        last_c  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                if (bus.req_valid) state_d = BID;
            end
            BID: begin
                bid_c = bid_calc;
                if (deduct) state_d = XFER;
            end
            XFER: begin
                bid_c = win_q;
                if (bus.grant) begin
                    beat_c = 1'b1;
                    last_c = (beat_q == len_q);
                    if (last_c) state_d = DONE;
                end else begin
                    state_d = BID;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q  <= 4'd0;
            prio_q <= 4'd0;
            beat_q <= 4'd0;
            win_q  <= 4'd0;
            wait_q <= 6'd0;
            rc_q   <= '0;
            bal_q  <= BAL_INIT_W;
        end else begin
            rc_q  <= refill_wrap ? '0 : rc_q + RC_W'(1);
            bal_q <= bal_d;
            case (state_q)
                IDLE: begin
                    beat_q <= 4'd0;
                    wait_q <= 6'd0;
                    if (bus.req_valid) begin
                        len_q  <= bus.req_len;
                        prio_q <= prio_in;
                    end
                end
                BID: begin
                    if (deduct) begin
                        wait_q <= 6'd0;
                        win_q  <= bid_calc;
                    end else if (wait_q != 6'd63) begin
                        wait_q <= wait_q + 6'd1;
                    end
                end
                XFER: begin
                    // beat count survives a lost grant so the next win resumes mid-request
                    if (bus.grant && !last_c) beat_q <= beat_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef BID_AGING_EN
    logic [3:0] age_cnt_q, age_prio_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_cnt_q  <= 4'd0;
            age_prio_q <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    age_cnt_q <= 4'd0;
                    if (bus.req_valid) age_prio_q <= prio_in;
                end
                BID: begin
                    if (deduct) begin
                        age_cnt_q  <= 4'd0;
                        age_prio_q <= prio_q;
                    end else begin
                        age_cnt_q <= age_cnt_q + 4'd1;
                        if (age_cnt_q == 4'd15 && age_prio_q != 4'd15)
                            age_prio_q <= age_prio_q + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign prio_eff = age_prio_q;
`else
    assign prio_eff = prio_q;
`endif

    assign bus.req_ready = ready_c;
    assign bus.bid       = bid_c;
    assign bus.balance   = bal_q[9:0];
    assign bus.xfer_beat = beat_c;
    assign bus.xfer_last = last_c;
    assign bus.starve    = ({1'b0, wait_q} >= STARVE_V);
endmodule

// File: tb/tb_bid_requester.sv
// Directed bench for bid_requester: a balance/refill model plus a beat scoreboard
// of expected xfer_last values, checked with immediate assertions.
module tb_bid_requester;
    localparam int RP = 400;
    localparam int RA = 750;
    localparam int BM = 900;
    localparam int BI = 750;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bid_requester_if bus();

    bid_requester dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int fails  = 0;
    int m_bal, m_rc, bc, cur_prio, b0, g;
    bit wrapped;
    bit sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_bid();
        int p;
        p = (cur_prio == 0) ? 1 : cur_prio;
`ifdef BID_AGING_EN
        p = p + bc / 16;
        if (p > 15) p = 15;
`endif
        if (m_bal <= 1) return 0;
        return (p < m_bal - 1) ? p : m_bal - 1;
    endfunction

    task automatic tick(input int ded);
        @(posedge clk);
        if (m_rc == RP - 1) begin
            m_rc    = 0;
            wrapped = 1'b1;
            m_bal   = (m_bal + RA > BM) ? BM : m_bal + RA;
        end else begin
            m_rc++;
        end
        m_bal = (m_bal > ded) ? m_bal - ded : 0;
        #1;
        chk("balance", 32'(bus.balance), m_bal);
    endtask

    task automatic do_req(input int len, input int prio);
        bus.req_valid = 1'b1;
        bus.req_len   = 4'(len);
        bus.req_prio  = 4'(prio);
        bus.grant     = 1'b0;
        #1;
        chk("idle_ready", 32'(bus.req_ready), 1);
        chk("idle_bid", 32'(bus.bid), 0);
        tick(0);
        bus.req_valid = 1'b0;
        bc       = 0;
        cur_prio = prio;
        for (int i = 0; i <= len; i++) sb_q.push_back(i == len);
    endtask

    task automatic win();
        int e;
        bus.grant = 1'b1;
        #1;
        e = exp_bid();
        chk("bid_win", 32'(bus.bid), e);
        chk("starve_win", 32'(bus.starve), (bc >= 60) ? 1 : 0);
        tick(e);
        bc = 0;
    endtask

    task automatic wait_bid(input int n, input logic gnt);
        for (int i = 0; i < n; i++) begin
            bus.grant = gnt;
            #1;
            chk("bid_wait", 32'(bus.bid), exp_bid());
            chk("starve_wait", 32'(bus.starve), (bc >= 60) ? 1 : 0);
            chk("ready_busy", 32'(bus.req_ready), 0);
            chk("beat_in_bid", 32'(bus.xfer_beat), 0);
            tick(0);
            bc++;
        end
    endtask

    task automatic beat_cycle();
        bit exp_last;
        bus.grant = 1'b1;
        #1;
        chk("xfer_beat", 32'(bus.xfer_beat), 1);
        chk("starve_xfer", 32'(bus.starve), 0);
        if (bus.xfer_beat === 1'b1) begin
            chk("sb_nonempty", (sb_q.size() != 0) ? 1 : 0, 1);
            exp_last = (sb_q.size() != 0) ? sb_q.pop_front() : 1'b0;
            chk("xfer_last", 32'(bus.xfer_last), exp_last);
        end
        tick(0);
    endtask

    task automatic nogrant_xfer();
        bus.grant = 1'b0;
        #1;
        chk("nogrant_beat", 32'(bus.xfer_beat), 0);
        chk("nogrant_last", 32'(bus.xfer_last), 0);
        tick(0);
    endtask

    task automatic done_cycle();
        bus.grant = 1'b1;
        #1;
        chk("done_beat", 32'(bus.xfer_beat), 0);
        chk("done_bid", 32'(bus.bid), 0);
        chk("done_ready", 32'(bus.req_ready), 0);
        tick(0);
        bus.grant = 1'b0;
    endtask

    task automatic drain_to(input int target);
        int p, guard;
        guard = 0;
        while (m_bal != target && guard < 300) begin
            p = m_bal - target;
            if (p > 15) p = 15;
            do_req(0, p);
            win();
            beat_cycle();
            done_cycle();
            guard++;
        end
        chk("drain_balance", 32'(bus.balance), target);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_len   = 4'd0;
        bus.req_prio  = 4'd0;
        bus.grant     = 1'b0;
        m_bal = BI; m_rc = 0; bc = 0; cur_prio = 1; wrapped = 1'b0;

        // reset holds outputs even with active inputs
        #2;
        bus.req_valid = 1'b1;
        bus.grant     = 1'b1;
        #10;
        chk("rst_ready", 32'(bus.req_ready), 1);
        chk("rst_balance", 32'(bus.balance), BI);
        chk("rst_bid", 32'(bus.bid), 0);
        chk("rst_beat", 32'(bus.xfer_beat), 0);
        chk("rst_last", 32'(bus.xfer_last), 0);
        chk("rst_starve", 32'(bus.starve), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.grant     = 1'b0;

        // basic transfer: len 3, prio 5, grant held
        do_req(3, 5);
        win();
        chk("basic_balance", 32'(bus.balance), 745);
        repeat (4) beat_cycle();
        done_cycle();
        bus.grant = 1'b1;
        #1;
        chk("idle_grant_beat", 32'(bus.xfer_beat), 0);
        chk("idle_grant_ready", 32'(bus.req_ready), 1);
        tick(0);
        bus.grant = 1'b0;

        // starvation and (when enabled) aging during a long wait
        do_req(0, 2);
        wait_bid(60, 1'b0);
        chk("starve_at_60", 32'(bus.starve), 1);
        wait_bid(5, 1'b0);
        win();
        beat_cycle();
        done_cycle();

        // split transfer: lose grant after 4 beats, win again, two deductions
        b0 = m_bal;
        do_req(7, 4);
        win();
        repeat (4) beat_cycle();
        nogrant_xfer();
        bus.req_valid = 1'b1;
        wait_bid(4, 1'b0);
        bus.req_valid = 1'b0;
        win();
        chk("split_two_deductions", 32'(bus.balance), b0 - 8);
        repeat (4) beat_cycle();
        chk("split_sb_drained", 32'(sb_q.size()), 0);
        done_cycle();

        // first refill saturates at BAL_MAX
        wrapped = 1'b0;
        g = 0;
        while (!wrapped && g < 450) begin
            tick(0);
            g++;
        end
        chk("refill_saturate", 32'(bus.balance), BM);

        // refill and a bid-6 win on the same edge
        drain_to(850);
        g = 0;
        while (m_rc != RP - 2 && g < 450) begin
            tick(0);
            g++;
        end
        do_req(0, 6);
        win();
        chk("refill_then_deduct", 32'(bus.balance), 894);
        beat_cycle();
        done_cycle();

        // low balance caps bid, then bid 0 until refill
        drain_to(3);
        do_req(0, 9);
        win();
        chk("low_balance_after_win", 32'(bus.balance), 1);
        beat_cycle();
        done_cycle();
        do_req(0, 9);
        wrapped = 1'b0;
        g = 0;
        while (!wrapped && g < 450) begin
            wait_bid(1, 1'b1);
            g++;
        end
        chk("refill_from_one", 32'(bus.balance), 751);
        win();
        beat_cycle();
        done_cycle();

        // reset in the middle of a transfer drops the request
        do_req(3, 5);
        win();
        beat_cycle();
        rst = 1'b0;
        #1;
        chk("midrst_ready", 32'(bus.req_ready), 1);
        chk("midrst_beat", 32'(bus.xfer_beat), 0);
        chk("midrst_last", 32'(bus.xfer_last), 0);
        chk("midrst_bid", 32'(bus.bid), 0);
        chk("midrst_balance", 32'(bus.balance), BI);
        chk("midrst_starve", 32'(bus.starve), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.grant = 1'b0;
        m_bal = BI; m_rc = 0; bc = 0;
        sb_q.delete();
        do_req(1, 0);
        win();
        repeat (2) beat_cycle();
        done_cycle();
        chk("final_sb_drained", 32'(sb_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
